// File: rtl/axilite_reg_access_arbiter_if.sv
// AXI-Lite bus bundle between the register-access arbiter (master) and the
// configuration slave.
interface axilite_reg_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   axi_awaddr;
    logic                axi_awvalid;
    logic                axi_awready;
    logic [DATA_W-1:0]   axi_wdata;
    logic [DATA_W/8-1:0] axi_wstrb;
    logic                axi_wvalid;
    logic                axi_wready;
    logic [1:0]          axi_bresp;
    logic                axi_bvalid;
    logic                axi_bready;
    logic [ADDR_W-1:0]   axi_araddr;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [DATA_W-1:0]   axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rvalid;
    logic                axi_rready;

    modport master (
        output axi_awaddr, axi_awvalid, input axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid, input axi_wready,
        input axi_bresp, axi_bvalid, output axi_bready,
        output axi_araddr, axi_arvalid, input axi_arready,
        input axi_rdata, axi_rresp, axi_rvalid, output axi_rready
    );

    modport slave (
        input axi_awaddr, axi_awvalid, output axi_awready,
        input axi_wdata, axi_wstrb, axi_wvalid, output axi_wready,
        output axi_bresp, axi_bvalid, input axi_bready,
        input axi_araddr, axi_arvalid, output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid, input axi_rready
    );
endinterface

// File: rtl/axilite_reg_access_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port between NUM_REQ
// single-beat register requesters, with a per-transaction timeout.
module axilite_reg_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic                      busy,
    axilite_reg_access_arbiter_if.master lite
);
    localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    last_reg, owner_reg, grant_idx;
    logic [IDX_W-1:0]    cand_idx [NUM_REQ];
    logic                grant_found;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                aw_done_reg, w_done_reg;
    logic [15:0]         tmo_cnt_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [1:0]          resp_reg;
    logic                timeout_reg;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                in_wait, expire, abort;

    // Candidate k is the (k+1)-th requester after the last grant, with wrap.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last_reg) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign aw_hs   = lite.axi_awvalid & lite.axi_awready;
    assign w_hs    = lite.axi_wvalid & lite.axi_wready;
    assign b_hs    = lite.axi_bvalid & lite.axi_bready;
    assign ar_hs   = lite.axi_arvalid & lite.axi_arready;
    assign r_hs    = lite.axi_rvalid & lite.axi_rready;
    assign in_wait = (state_reg == WR_REQ) || (state_reg == WR_RSP) ||
                     (state_reg == RD_REQ) || (state_reg == RD_RSP);
    // A completing handshake in the expiry cycle takes priority over the abort.
    assign expire  = (tmo_cnt_reg >= TMO_LAST);

    always_ff @(posedge clock) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        unique case (state_reg)
            IDLE:   if (grant_found) state_next = req_write[grant_idx] ? WR_REQ : RD_REQ;
            WR_REQ: begin
                if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) state_next = WR_RSP;
                else if (expire) begin abort = 1'b1; state_next = DONE; end
            end
            WR_RSP: begin
                if (b_hs) state_next = DONE;
                else if (expire) begin abort = 1'b1; state_next = DONE; end
            end
            RD_REQ: begin
                if (ar_hs) state_next = RD_RSP;
                else if (expire) begin abort = 1'b1; state_next = DONE; end
            end
            RD_RSP: begin
                if (r_hs) state_next = DONE;
                else if (expire) begin abort = 1'b1; state_next = DONE; end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            last_reg    <= IDX_W'(NUM_REQ - 1);
            owner_reg   <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
            rdata_reg   <= '0;
            resp_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && grant_found) begin
                owner_reg   <= grant_idx;
                last_reg    <= grant_idx;
                addr_reg    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                wdata_reg   <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
                tmo_cnt_reg <= '0;
            end
            if (in_wait) tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            if (aw_hs)   aw_done_reg <= 1'b1;
            if (w_hs)    w_done_reg  <= 1'b1;
            if (b_hs) begin
                rdata_reg   <= '0;
                resp_reg    <= lite.axi_bresp;
                timeout_reg <= 1'b0;
            end
            if (r_hs) begin
                rdata_reg   <= lite.axi_rdata;
                resp_reg    <= lite.axi_rresp;
                timeout_reg <= 1'b0;
            end
            if (abort) begin
                rdata_reg   <= '0;
                resp_reg    <= 2'b10;
                timeout_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready        = '0;
        rsp_valid        = '0;
        lite.axi_awvalid = 1'b0;
        lite.axi_wvalid  = 1'b0;
        lite.axi_bready  = 1'b0;
        lite.axi_arvalid = 1'b0;
        lite.axi_rready  = 1'b0;
        if (state_reg == IDLE && grant_found && !rst) req_ready = NUM_REQ'(1) << grant_idx;
        if (state_reg == DONE) rsp_valid = NUM_REQ'(1) << owner_reg;
        if (state_reg == WR_REQ) begin
            lite.axi_awvalid = ~aw_done_reg;
            lite.axi_wvalid  = ~w_done_reg;
        end
        if (state_reg == WR_RSP) lite.axi_bready  = 1'b1;
        if (state_reg == RD_REQ) lite.axi_arvalid = 1'b1;
        if (state_reg == RD_RSP) lite.axi_rready  = 1'b1;
    end

    assign busy            = (state_reg != IDLE);
    assign rsp_rdata       = rdata_reg;
    assign rsp_resp        = resp_reg;
    assign rsp_timeout     = timeout_reg;
    assign lite.axi_awaddr = addr_reg;
    assign lite.axi_araddr = addr_reg;
    assign lite.axi_wdata  = wdata_reg;
    assign lite.axi_wstrb  = '1;
endmodule
